// File: rtl/nco_keyed_carrier.sv
// Keyed square-wave carrier: a phase-accumulator NCO gated by a valid/ready symbol engine.
// Supports off, CW, OOK and binary FSK; carrier_out is registered from the accumulator MSB.
module nco_keyed_carrier #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned CARRIER_HZ = 500_000,
    parameter int unsigned DEV_HZ     = 50_000,
    parameter int unsigned BAUD       = 10_000,
    parameter int unsigned ACC_W      = 32
) (
    input  logic       CLK,
    input  logic       reset_trigger,
    input  logic       enable,
    input  logic [1:0] mode,
    input  logic       sym_data,
    input  logic       sym_valid,
    output logic       sym_ready,
    output logic       busy,
    output logic       sym_strobe,
    output logic       carrier_out
);

    localparam int unsigned BAUD_DIV = CLK_HZ / BAUD;
    localparam int unsigned TMR_W    = $clog2(BAUD_DIV);

    // Tuning words: floor(F * 2^ACC_W / CLK_HZ), evaluated in 64 bits to avoid overflow.
    localparam logic [63:0] FTW_C_WIDE = (64'(CARRIER_HZ) << ACC_W) / 64'(CLK_HZ);
    localparam logic [63:0] FTW_S_WIDE = (64'(CARRIER_HZ - DEV_HZ) << ACC_W) / 64'(CLK_HZ);
    localparam logic [63:0] FTW_M_WIDE = (64'(CARRIER_HZ + DEV_HZ) << ACC_W) / 64'(CLK_HZ);
    localparam logic [ACC_W-1:0] FTW_C = FTW_C_WIDE[ACC_W-1:0];
    localparam logic [ACC_W-1:0] FTW_S = FTW_S_WIDE[ACC_W-1:0];
    localparam logic [ACC_W-1:0] FTW_M = FTW_M_WIDE[ACC_W-1:0];

    typedef enum logic [1:0] {
        MODE_OFF = 2'b00,
        MODE_CW  = 2'b01,
        MODE_OOK = 2'b10,
        MODE_FSK = 2'b11
    } mode_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    mode_t              mode_sel;
    state_t             state, state_nxt;
    logic [TMR_W-1:0]   timer, timer_nxt;
    logic               cur_bit, cur_bit_nxt;
    logic [ACC_W-1:0]   acc, ftw_sel;
    logic               active, handshake, carrier_raw, carrier_gated;

    assign mode_sel    = mode_t'(mode);
    assign carrier_raw = acc[ACC_W-1];

    // Symbol engine: next state and handshake outputs.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and infers a latch.
        state_nxt   = state;
        timer_nxt   = timer;
        cur_bit_nxt = cur_bit;

        active     = enable && (mode_sel != MODE_OFF);
        busy       = (state == SEND);
        // Outputs are forced low while reset is held, even before any clock edge.
        sym_ready  = active && !reset_trigger && ((state == IDLE) || (timer == '0));
        sym_strobe = active && !reset_trigger && (state == SEND) && (timer == '0);
        handshake  = sym_ready && sym_valid;

        if (enable) begin
            if (mode_sel == MODE_OFF) begin
                state_nxt = IDLE;
                timer_nxt = '0;
            end else if (handshake) begin
                state_nxt   = SEND;
                cur_bit_nxt = sym_data;
                timer_nxt   = TMR_W'(BAUD_DIV - 1);
            end else if (state == SEND) begin
                if (timer == '0) begin
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer - TMR_W'(1);
                end
            end
        end
    end

    // Tuning-word select and output keying.
    always_comb begin
        ftw_sel = FTW_C;
        if (mode_sel == MODE_FSK) begin
            // Idle in FSK holds the mark tone.
            ftw_sel = ((state == SEND) && !cur_bit) ? FTW_S : FTW_M;
        end

        carrier_gated = 1'b0;
        case (mode_sel)
            MODE_CW, MODE_FSK: carrier_gated = carrier_raw;
            MODE_OOK:          carrier_gated = carrier_raw && busy && cur_bit;
            default:           carrier_gated = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or posedge reset_trigger) begin
        if (reset_trigger) begin
            acc         <= '0;
            timer       <= '0;
            state       <= IDLE;
            cur_bit     <= 1'b0;
            carrier_out <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
            carrier_out <= enable && carrier_gated;
            state       <= state_nxt;
            timer       <= timer_nxt;
            cur_bit     <= cur_bit_nxt;
            // Only entry to the off mode clears phase; all other switches stay phase-continuous.
            if (enable) begin
                acc <= (mode_sel == MODE_OFF) ? '0 : acc + ftw_sel;
            end
        end
    end

endmodule

// File: tb/tb_nco_keyed_carrier.sv
// Self-checking bench for nco_keyed_carrier: directed scenarios plus random traffic,
// compared cycle by cycle against a phase/symbol reference model.
module tb_nco_keyed_carrier;

    localparam int unsigned CLK_HZ     = 100_000_000;
    localparam int unsigned CARRIER_HZ = 5_000_000;
    localparam int unsigned DEV_HZ     = 1_000_000;
    localparam int unsigned BAUD       = 1_000_000;
    localparam int          BAUD_DIV   = CLK_HZ / BAUD;

    logic       CLK = 1'b0;
    logic       reset_trigger;
    logic       enable;
    logic [1:0] mode;
    logic       sym_data;
    logic       sym_valid;
    logic       sym_ready;
    logic       busy;
    logic       sym_strobe;
    logic       carrier_out;

    nco_keyed_carrier #(
        .CLK_HZ    (CLK_HZ),
        .CARRIER_HZ(CARRIER_HZ),
        .DEV_HZ    (DEV_HZ),
        .BAUD      (BAUD),
        .ACC_W     (32)
    ) dut (
        .CLK          (CLK),
        .reset_trigger(reset_trigger),
        .enable       (enable),
        .mode         (mode),
        .sym_data     (sym_data),
        .sym_valid    (sym_valid),
        .sym_ready    (sym_ready),
        .busy         (busy),
        .sym_strobe   (sym_strobe),
        .carrier_out  (carrier_out)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: phase as a wrapping 32-bit number, symbol as a count of clocks left.
    logic [31:0] ftw_c, ftw_s, ftw_m;
    logic [31:0] m_phase;
    bit          m_send;
    int          m_rem;
    bit          m_bit;
    bit          m_car;
    bit          m_hs;

    int strobe_cnt, strobe_cyc, hs_cyc, busy_cnt, ready_busy_cnt, rises;
    bit prev_car;

    function automatic logic [31:0] tuning_word(input longint unsigned f_hz);
        longint unsigned w;
        w = (f_hz << 32) / longint'(CLK_HZ);
        return w[31:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic clear_counts();
        strobe_cnt = 0; strobe_cyc = -1; hs_cyc = -1;
        busy_cnt = 0; ready_busy_cnt = 0; rises = 0;
    endtask

    // One clock: drive inputs, compare outputs against the model, advance the model.
    task automatic step(input bit en, input bit [1:0] md, input bit v, input bit d);
        bit          act, e_rdy, e_stb, nxt_car;
        logic [31:0] ftw;
        enable = en; mode = md; sym_valid = v; sym_data = d;
        #3;
        act   = en && (md != 2'b00);
        e_rdy = act && (!m_send || m_rem == 1);
        e_stb = act && m_send && (m_rem == 1);
        check("carrier_out", 32'(carrier_out), 32'(m_car));
        check("sym_ready",   32'(sym_ready),   32'(e_rdy));
        check("busy",        32'(busy),        32'(m_send));
        check("sym_strobe",  32'(sym_strobe),  32'(e_stb));

        if (sym_strobe) begin strobe_cnt++; strobe_cyc = cyc; end
        if (busy) busy_cnt++;
        if (busy && sym_ready) ready_busy_cnt++;
        if (carrier_out && !prev_car) rises++;
        prev_car = carrier_out;

        m_hs = e_rdy && v;
        if (m_hs) hs_cyc = cyc;
        nxt_car = 1'b0;
        if (en) begin
            case (md)
                2'b01:   nxt_car = m_phase[31];
                2'b10:   nxt_car = m_send && m_bit && m_phase[31];
                2'b11:   nxt_car = m_phase[31];
                default: nxt_car = 1'b0;
            endcase
            if (md == 2'b11) ftw = !m_send ? ftw_m : (m_bit ? ftw_m : ftw_s);
            else             ftw = ftw_c;
            m_phase = (md == 2'b00) ? 32'd0 : m_phase + ftw;
            if (md == 2'b00) begin
                m_send = 1'b0;
            end else if (m_hs) begin
                m_send = 1'b1; m_rem = BAUD_DIV; m_bit = d;
            end else if (m_send) begin
                if (m_rem == 1) m_send = 1'b0;
                else m_rem--;
            end
        end
        m_car = nxt_car;
        @(posedge CLK); #1;
        cyc++;
    endtask

    // Short asynchronous reset pulse between edges; the caller finishes the cycle with step().
    task automatic reset_pulse(input bit en, input bit [1:0] md);
        enable = en; mode = md; sym_valid = 1'b0; sym_data = 1'b0;
        #1 reset_trigger = 1'b1;
        #1;
        check("pulse_carrier", 32'(carrier_out), 32'd0);
        check("pulse_ready",   32'(sym_ready),   32'd0);
        check("pulse_busy",    32'(busy),        32'd0);
        check("pulse_strobe",  32'(sym_strobe),  32'd0);
        #2 reset_trigger = 1'b0;
        m_phase = 32'd0; m_send = 1'b0; m_car = 1'b0; m_rem = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        bit bits [3];
        int k;
        bit [1:0] cur_md;

        ftw_c = tuning_word(CARRIER_HZ);
        ftw_s = tuning_word(CARRIER_HZ - DEV_HZ);
        ftw_m = tuning_word(CARRIER_HZ + DEV_HZ);
        m_phase = 32'd0; m_send = 1'b0; m_rem = 0; m_bit = 1'b0; m_car = 1'b0; m_hs = 1'b0;
        prev_car = 1'b0;
        clear_counts();

        // Reset held with CW requested: every output stays low.
        reset_trigger = 1'b1; enable = 1'b1; mode = 2'b01; sym_valid = 1'b0; sym_data = 1'b0;
        repeat (10) begin
            @(posedge CLK); #1;
            check("rst_carrier", 32'(carrier_out), 32'd0);
            check("rst_ready",   32'(sym_ready),   32'd0);
            check("rst_busy",    32'(busy),        32'd0);
            check("rst_strobe",  32'(sym_strobe),  32'd0);
        end
        reset_trigger = 1'b0;

        // CW: 5 MHz from a 100 MHz clock gives a 20-clock period, ~10 rising edges in 200 clocks.
        clear_counts();
        repeat (200) step(1, 2'b01, 0, 0);
        check("cw_rise_count_in_range", 32'(rises >= 9 && rises <= 11), 32'd1);

        // BFSK: one space symbol, then mark-hold idle.
        clear_counts();
        step(1, 2'b11, 1, 0);
        repeat (120) step(1, 2'b11, 0, 0);
        check("fsk_strobe_count", 32'(strobe_cnt), 32'd1);
        check("fsk_symbol_length", 32'(strobe_cyc - hs_cyc), 32'(BAUD_DIV));

        // OOK: valid held high across three back-to-back symbols 1,0,1.
        clear_counts();
        bits = '{1'b1, 1'b0, 1'b1};
        k = 0;
        repeat (3 * BAUD_DIV + 5) begin
            if (k < 3) step(1, 2'b10, 1, bits[k]);
            else       step(1, 2'b10, 0, 0);
            if (m_hs) k++;
        end
        check("ook_strobe_count", 32'(strobe_cnt), 32'd3);
        check("ook_busy_cycles", 32'(busy_cnt), 32'(3 * BAUD_DIV));
        check("ook_ready_while_busy", 32'(ready_busy_cnt), 32'd3);

        // Enable gap of 50 clocks, 40 clocks into a mark symbol.
        clear_counts();
        step(1, 2'b11, 1, 1);
        repeat (40) step(1, 2'b11, 0, 0);
        check("acc_before_gap", dut.acc, m_phase);
        repeat (50) step(0, 2'b11, 0, 0);
        check("acc_after_gap", dut.acc, m_phase);
        repeat (70) step(1, 2'b11, 0, 0);
        check("gap_strobe_count", 32'(strobe_cnt), 32'd1);
        check("gap_symbol_length", 32'(strobe_cyc - hs_cyc), 32'(BAUD_DIV + 50));

        // Abort: BFSK to off mid-symbol, then CW restarting from phase zero.
        clear_counts();
        step(1, 2'b11, 1, 1);
        repeat (30) step(1, 2'b11, 0, 0);
        step(1, 2'b00, 0, 0);
        check("acc_cleared_on_off", dut.acc, m_phase);
        repeat (5) step(1, 2'b00, 0, 0);
        check("abort_no_strobe", 32'(strobe_cnt), 32'd0);
        repeat (60) step(1, 2'b01, 0, 0);

        // Asynchronous reset pulse while sending with the carrier high.
        step(1, 2'b01, 1, 1);
        repeat (20) step(1, 2'b01, 0, 0);
        for (int i = 0; i < 30 && !carrier_out; i++) step(1, 2'b01, 0, 0);
        check("carrier_high_before_pulse", 32'(carrier_out), 32'd1);
        reset_pulse(1, 2'b01);
        step(1, 2'b01, 0, 0);
        repeat (30) step(1, 2'b01, 0, 0);

        // Random traffic: occasional mode changes, short enable drops, random offers.
        cur_md = 2'b11;
        repeat (800) begin
            if ($urandom_range(39) == 0) cur_md = 2'($urandom_range(3));
            step($urandom_range(15) != 0, cur_md, 1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
